// File: rtl/uart_cmd_decoder.sv
// Decodes SOF/CMD/ARG/CHK byte frames into checked commands. cmd_valid rises 1 cycle after CHK.
// rx_ready drops while a decoded command waits in HOLD, so the uart stalls until cmd_ready.
`timescale 1ns/1ps
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  SOF_BYTE       = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       frame_err,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK,
    HOLD
  } state_t;

  localparam logic [22:0] GAP_LAST = 23'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  arg_q, arg_d;
  logic [7:0]  cmd_buf_q, cmd_buf_d;
  logic [7:0]  arg_buf_q, arg_buf_d;
  logic [22:0] gap_q, gap_d;

  logic accept;
  logic in_frame;
  logic timeout;
  logic err_pulse;

  assign accept   = rx_valid & rx_ready_q;
  assign in_frame = (state_q == GET_CMD) || (state_q == GET_ARG) || (state_q == GET_CHK);
  // An accepted byte on the threshold cycle beats the timeout.
  assign timeout  = in_frame && !accept && (gap_q == GAP_LAST);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    cmd_buf_d = cmd_buf_q;
    arg_buf_d = arg_buf_q;
    err_pulse = 1'b0;
    gap_d     = 23'd0;

    if (in_frame && !accept && !timeout) begin
      gap_d = gap_q + 23'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept && (rx_data == SOF_BYTE)) begin
          state_d = GET_CMD;
        end
      end
      GET_CMD: begin
        if (accept) begin
          cmd_buf_d = rx_data;
          state_d   = GET_ARG;
        end
      end
      GET_ARG: begin
        if (accept) begin
          arg_buf_d = rx_data;
          state_d   = GET_CHK;
        end
      end
      GET_CHK: begin
        if (accept) begin
          if (rx_data == (cmd_buf_q ^ arg_buf_q)) begin
            cmd_d   = cmd_buf_q;
            arg_d   = arg_buf_q;
            state_d = HOLD;
          end else begin
            err_pulse = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        if (cmd_valid_q && cmd_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      err_pulse = 1'b1;
      state_d   = IDLE;
    end

    err_count_d = (err_pulse && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
    rx_ready_d  = (state_d != HOLD);
    cmd_valid_d = (state_d == HOLD);
    frame_err_d = err_pulse;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= 8'd0;
      cmd_q       <= 8'd0;
      arg_q       <= 8'd0;
      cmd_buf_q   <= 8'd0;
      arg_buf_q   <= 8'd0;
      gap_q       <= 23'd0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cmd_buf_q   <= cmd_buf_d;
      arg_buf_q   <= arg_buf_d;
      gap_q       <= gap_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame table, hold/timeout/saturation/reset sequences, random frame stream.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       frame_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .SOF_BYTE(8'h23)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cmd       (cmd),
    .arg       (arg),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] bytes;
    logic        ok;
    logic [7:0]  ecmd;
    logic [7:0]  earg;
    logic [7:0]  eerr;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] got_q[$];
  int          err_seen = 0;
  int          consec_err = 0;
  logic        prev_err = 1'b0;

  // Observer: completed command handshakes and frame_err pulses.
  initial forever begin
    @(negedge clk);
    if (cmd_valid && cmd_ready) got_q.push_back({cmd, arg});
    if (frame_err) begin
      err_seen++;
      if (prev_err) consec_err++;
    end
    prev_err = frame_err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!rx_ready) chk("byte_accept_wait", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_byte(f[31:24]);
    send_byte(f[23:16]);
    send_byte(f[15:8]);
    send_byte(f[7:0]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  vec_t        tbl[6];
  int          viol;
  int          e0;
  int          base;
  int          exp_err;
  logic [15:0] exp_q[$];
  bit          done;
  logic [7:0]  c, a, k, jb;
  int          nj;
  bit          good;

  initial begin
    tbl[0] = '{32'h23410544, 1'b1, 8'h41, 8'h05, 8'd0};
    tbl[1] = '{32'h23410545, 1'b0, 8'h41, 8'h05, 8'd1};
    tbl[2] = '{32'h23230023, 1'b1, 8'h23, 8'h00, 8'd1};
    tbl[3] = '{32'h23102030, 1'b1, 8'h10, 8'h20, 8'd1};
    tbl[4] = '{32'h23FFFF01, 1'b0, 8'h10, 8'h20, 8'd2};
    tbl[5] = '{32'h23000000, 1'b1, 8'h00, 8'h00, 8'd2};

    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cmd_ready = 1'b0;

    // Reset values, then rx_ready rising on the first edge after release.
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rx_ready, cmd_valid, frame_err, cmd, arg, err_count}, 0);
    reset = 1'b0;
    #1 chk("rx_ready_before_first_edge", rx_ready, 0);
    @(negedge clk);
    chk("rx_ready_after_first_edge", rx_ready, 1);
    tick();

    // Frame table with cmd_ready held high.
    cmd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].bytes);
      @(negedge clk);
      chk("tbl_cmd_valid", cmd_valid, tbl[i].ok);
      chk("tbl_frame_err", frame_err, !tbl[i].ok);
      chk("tbl_cmd", cmd, tbl[i].ecmd);
      chk("tbl_arg", arg, tbl[i].earg);
      chk("tbl_err_count", err_count, tbl[i].eerr);
      tick();
      @(negedge clk);
      chk("tbl_cmd_valid_drop", cmd_valid, 0);
      chk("tbl_frame_err_drop", frame_err, 0);
      tick();
    end

    // Leading junk, then a command held 50 cycles with a byte on offer.
    cmd_ready = 1'b0;
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(32'h23102030);
    @(negedge clk);
    chk("hold_cmd_valid", cmd_valid, 1);
    chk("hold_cmd_arg", {cmd, arg}, 16'h1020);
    chk("hold_rx_ready", rx_ready, 0);
    tick();
    rx_data = 8'h23; rx_valid = 1'b1;
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (!(cmd_valid && cmd == 8'h10 && arg == 8'h20 && !rx_ready)) viol++;
    end
    chk("hold_50_cycles", viol, 0);
    tick();
    rx_valid = 1'b0; cmd_ready = 1'b1;
    @(negedge clk);
    chk("hold_valid_until_ready", cmd_valid, 1);
    tick();
    @(negedge clk);
    chk("hold_release_valid", cmd_valid, 0);
    chk("hold_release_rx_ready", rx_ready, 1);
    chk("junk_no_error", err_count, 2);
    tick();

    // Timeout after 16 idle cycles in GET_ARG; FSM must be back in IDLE.
    send_byte(8'h23); send_byte(8'h41);
    viol = 0;
    repeat (16) begin
      @(negedge clk);
      if (frame_err) viol++;
    end
    chk("no_err_before_timeout", viol, 0);
    @(negedge clk);
    chk("timeout_pulse", frame_err, 1);
    chk("timeout_err_count", err_count, 3);
    @(negedge clk);
    chk("timeout_single_pulse", frame_err, 0);
    tick();
    send_byte(8'h10);
    send_frame(32'h23AA55FF);
    @(negedge clk);
    chk("after_timeout_decode", {cmd_valid, cmd, arg}, {1'b1, 16'hAA55});
    tick();

    // A byte landing on the threshold cycle wins over the timeout.
    e0 = err_seen;
    send_byte(8'h23); send_byte(8'h41);
    repeat (15) tick();
    send_byte(8'h05);
    send_byte(8'h44);
    @(negedge clk);
    chk("late_byte_decode", {cmd_valid, cmd, arg}, {1'b1, 16'h4105});
    chk("late_byte_no_timeout", err_seen - e0, 0);
    chk("late_byte_err_count", err_count, 3);
    tick();

    // Saturation over 256 bad frames.
    pulse_reset();
    for (int f = 0; f < 256; f++) begin
      send_frame(32'h23010200);
      @(negedge clk);
      if (f == 0)   chk("sat_first", err_count, 1);
      if (f == 254) chk("sat_255th", err_count, 8'hFF);
      if (f == 255) begin
        chk("sat_256th_count", err_count, 8'hFF);
        chk("sat_256th_pulse", frame_err, 1);
        chk("sat_cmd_untouched", {cmd_valid, cmd, arg}, 0);
      end
      tick();
    end

    // Reset in GET_ARG and in HOLD.
    e0 = err_seen;
    send_byte(8'h23); send_byte(8'h41);
    #2 reset = 1'b1;
    #1 chk("rst_get_arg_outputs", {rx_ready, cmd_valid, frame_err, cmd, arg, err_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    cmd_ready = 1'b0;
    send_frame(32'h23123426);
    @(negedge clk);
    chk("pre_hold_reset", {cmd_valid, cmd, arg}, {1'b1, 16'h1234});
    #2 reset = 1'b1;
    #1 chk("rst_hold_outputs", {rx_ready, cmd_valid, frame_err, cmd, arg, err_count}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    cmd_ready = 1'b1;
    send_frame(32'h235A0F55);
    @(negedge clk);
    chk("post_reset_decode", {cmd_valid, cmd, arg, err_count}, {1'b1, 24'h5A0F00});
    chk("reset_no_frame_err", err_seen - e0, 0);
    tick();

    // Random frame stream with random cmd_ready, checked against a frame-level model.
    exp_err = 0;
    base = got_q.size();
    e0 = err_seen;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 60; f++) begin
          nj = $urandom_range(0, 2);
          for (int j = 0; j < nj; j++) begin
            jb = 8'($urandom);
            if (jb == 8'h23) jb = 8'h24;
            send_byte(jb);
          end
          c = 8'($urandom);
          a = 8'($urandom);
          good = ($urandom_range(0, 3) != 0);
          k = c ^ a;
          if (!good) k = k ^ 8'($urandom_range(1, 255));
          send_byte(8'h23);
          repeat ($urandom_range(0, 5)) tick();
          send_byte(c);
          repeat ($urandom_range(0, 5)) tick();
          send_byte(a);
          repeat ($urandom_range(0, 5)) tick();
          send_byte(k);
          if (good) exp_q.push_back({c, a});
          else exp_err++;
          repeat ($urandom_range(0, 3)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 cmd_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    cmd_ready = 1'b1;
    repeat (4) tick();
    chk("rand_cmd_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) chk("rand_cmd_arg", got_q[base + i], exp_q[i]);
    end
    chk("rand_err_count", err_count, (exp_err > 255) ? 255 : exp_err);
    chk("rand_err_pulses", err_seen - e0, exp_err);
    chk("no_consecutive_frame_err", consec_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
